tx_arbiter_module: RTL and testbench

Round-robin arbiter/sequencer that shares one UART transmitter (tx_module) between N_REQ byte producers.
- Accepts one byte per request using a req/ack handshake.
- Drives the transmitter's TX_Data and TX_En_Sig, then waits for TX_Done_Sig.
- Returns a one-cycle acknowledge to the winning requester.
- Sits between the application blocks (command echo, status reporter, debug dump, etc.) and the single tx_module instance in the UART top.

---
 rtl/tx_arbiter_module.sv | 127 ++++++++++++
 tb/tb_tx_arbiter_module.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter_module.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Optional send watchdog enabled by defining TX_ARB_TIMEOUT_EN.
module tx_arbiter_module #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [N_REQ-1:0]     Req,
  input  logic [8*N_REQ-1:0]   Req_Data,
  output logic [N_REQ-1:0]     Grant_Ack,
  output logic [ID_W-1:0]      Grant_Id,
  output logic                 Busy,
  output logic [7:0]           TX_Data,
  output logic                 TX_En_Sig,
  input  logic                 TX_Done_Sig,
  output logic                 Tx_Err
);

  if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("tx_arbiter_module: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic [7:0]         win_data;
  logic [ID_W-1:0]    next_ptr;
  logic [N_REQ-1:0]   req_rot;
  logic [8*N_REQ-1:0] data_sh;
  int unsigned        idx;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    req_rot = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      req_rot = Req >> idx;
      if (!win_vld && req_rot[0]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    data_sh  = Req_Data >> (8 * win_id);
    win_data = data_sh[7:0];
    next_ptr = (Grant_Id == ID_W'(N_REQ - 1)) ? '0 : Grant_Id + 1'b1;
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
`else
  assign Tx_Err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      ptr       <= '0;
      TX_Data   <= '0;
      TX_En_Sig <= 1'b0;
      Grant_Ack <= '0;
      Grant_Id  <= '0;
      Busy      <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      Tx_Err    <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            TX_Data   <= win_data;
            Grant_Id  <= win_id;
            TX_En_Sig <= 1'b1;
            Busy      <= 1'b1;
            state     <= SEND;
`ifdef TX_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        SEND: begin
          // Done has priority over the watchdog limit on the same cycle.
          if (TX_Done_Sig) begin
            TX_En_Sig <= 1'b0;
            Grant_Ack <= N_REQ'(1) << Grant_Id;
            ptr       <= next_ptr;
            state     <= GAP;
          end
`ifdef TX_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_LIMIT) begin
            TX_En_Sig <= 1'b0;
            Tx_Err    <= 1'b1;
            ptr       <= next_ptr;
            state     <= GAP;
          end else begin
            wd_cnt    <= wd_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          Grant_Ack <= '0;
          Busy      <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
          Tx_Err    <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter_module.sv
// Self-checking bench for tx_arbiter_module: transaction-level model plus directed vectors.
module tb_tx_arbiter_module;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 20;

  logic           CLK = 1'b0;
  logic           RSTn = 1'b1;
  logic [N-1:0]   Req = '0;
  logic [8*N-1:0] Req_Data = '0;
  logic           TX_Done_Sig = 1'b0;
  logic [N-1:0]   Grant_Ack;
  logic [IDW-1:0] Grant_Id;
  logic           Busy;
  logic [7:0]     TX_Data;
  logic           TX_En_Sig;
  logic           Tx_Err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  tx_arbiter_module #(
    .N_REQ(N),
    .ID_W(IDW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .Req(Req),
    .Req_Data(Req_Data),
    .Grant_Ack(Grant_Ack),
    .Grant_Id(Grant_Id),
    .Busy(Busy),
    .TX_Data(TX_Data),
    .TX_En_Sig(TX_En_Sig),
    .TX_Done_Sig(TX_Done_Sig),
    .Tx_Err(Tx_Err)
  );

  always #5 CLK = ~CLK;

  // Model: requester with the smallest rotated distance from the pointer wins.
  function automatic int pick(input logic [N-1:0] r, input int p);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = (i - p + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  logic         m_en = 1'b0;
  logic [7:0]   m_data = '0;
  int           m_id = 0;
  int           m_ptr = 0;
  logic [N-1:0] m_ack = '0;
  logic         m_busy = 1'b0;
  logic         m_err = 1'b0;
  logic         m_gap = 1'b0;
  int           m_wd = 0;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_en <= 1'b0; m_data <= '0; m_id <= 0; m_ptr <= 0;
      m_ack <= '0; m_busy <= 1'b0; m_err <= 1'b0; m_gap <= 1'b0; m_wd <= 0;
    end else if (m_gap) begin
      m_gap <= 1'b0; m_ack <= '0; m_busy <= 1'b0; m_err <= 1'b0;
    end else if (m_en) begin
      if (TX_Done_Sig) begin
        m_en <= 1'b0; m_ack <= N'(1) << m_id; m_ptr <= (m_id + 1) % N; m_gap <= 1'b1;
      end
`ifdef TX_ARB_TIMEOUT_EN
      else if (m_wd == TO - 1) begin
        m_en <= 1'b0; m_err <= 1'b1; m_ptr <= (m_id + 1) % N; m_gap <= 1'b1;
      end else begin
        m_wd <= m_wd + 1;
      end
`endif
    end else if (Req != '0) begin
      m_id   <= pick(Req, m_ptr);
      m_data <= Req_Data[8*pick(Req, m_ptr) +: 8];
      m_en   <= 1'b1;
      m_busy <= 1'b1;
      m_wd   <= 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_tx_en", 32'(TX_En_Sig), 32'(m_en));
      check("cyc_tx_data", 32'(TX_Data), 32'(m_data));
      check("cyc_grant_id", 32'(Grant_Id), m_id);
      check("cyc_grant_ack", 32'(Grant_Ack), 32'(m_ack));
      check("cyc_busy", 32'(Busy), 32'(m_busy));
      check("cyc_tx_err", 32'(Tx_Err), 32'(m_err));
      check("cyc_ack_onehot0", 32'($onehot0(Grant_Ack)), 32'd1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_en(output int n);
    n = 0;
    while (TX_En_Sig !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (TX_En_Sig !== 1'b1) begin
      bad++;
      $display("FAIL wait_en: TX_En_Sig never rose within %0d cycles at %0t", n, $time);
    end
  endtask

  task automatic frame();
    repeat (2) tick();
    TX_Done_Sig = 1'b1;
    tick();
    TX_Done_Sig = 1'b0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    repeat (3) tick();
    RSTn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int sp;
    int low;
    int e_id [5];
    logic [7:0] e_dat [5];
    e_id  = '{0, 1, 2, 3, 0};
    e_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    #2;
    RSTn = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_en", 32'(TX_En_Sig), 0);
    check("rst_id", 32'(Grant_Id), 0);
    repeat (3) tick();
    RSTn = 1'b1;

    // Single request, 1-cycle launch latency, 1-cycle ack.
    Req_Data[7:0] = 8'hA5;
    Req = 4'b0001;
    tick();
    check("t1_en", 32'(TX_En_Sig), 1);
    check("t1_data", 32'(TX_Data), 32'hA5);
    check("t1_id", 32'(Grant_Id), 0);
    repeat (2) tick();
    TX_Done_Sig = 1'b1;
    tick();
    TX_Done_Sig = 1'b0;
    Req = '0;
    check("t1_ack", 32'(Grant_Ack), 32'b0001);
    check("t1_en_low", 32'(TX_En_Sig), 0);
    tick();
    check("t1_ack_clear", 32'(Grant_Ack), 0);

    // Done while idle must be ignored.
    tick();
    TX_Done_Sig = 1'b1;
    tick();
    TX_Done_Sig = 1'b0;
    check("idle_done_ack", 32'(Grant_Ack), 0);
    check("idle_done_busy", 32'(Busy), 0);

    // All four requesting: strict rotation and inter-frame spacing.
    do_reset();
    Req_Data = 32'h44332211;
    Req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_en(n);
      check("t2_id", 32'(Grant_Id), e_id[f]);
      check("t2_data", 32'(TX_Data), 32'(e_dat[f]));
      frame();
      if (f < 4) begin
        sp = 1;
        low = 0;
        while (TX_En_Sig == 1'b0 && sp < 10) begin
          low++;
          tick();
          sp++;
        end
        check("t2_done_to_en", sp, 3);
        check("t2_gap_ge2", 32'(low >= 2), 1);
      end else begin
        Req = 4'b0010;
      end
    end

    // Pointer wrap: grant 1, then {0,1} pending goes to 0 then 1.
    wait_en(n);
    check("t3_first", 32'(Grant_Id), 1);
    frame();
    Req = 4'b0011;
    wait_en(n);
    check("t3_wrap", 32'(Grant_Id), 0);
    frame();
    Req = 4'b0010;
    wait_en(n);
    check("t3_second", 32'(Grant_Id), 1);
    frame();
    Req = '0;

    // Request dropped mid-frame still gets its ack; no relaunch.
    Req = 4'b0010;
    wait_en(n);
    tick();
    Req = '0;
    repeat (3) tick();
    TX_Done_Sig = 1'b1;
    tick();
    TX_Done_Sig = 1'b0;
    check("t4_ack", 32'(Grant_Ack), 32'b0010);
    repeat (4) tick();
    check("t4_no_launch", 32'(TX_En_Sig), 0);
    check("t4_idle", 32'(Busy), 0);

    // Reset mid-frame: async drop, no ack, pointer back to 0.
    Req = 4'b0100;
    wait_en(n);
    check("t5_id", 32'(Grant_Id), 2);
    tick();
    RSTn = 1'b0;
    #1;
    check("t5_async_en", 32'(TX_En_Sig), 0);
    check("t5_async_busy", 32'(Busy), 0);
    Req = 4'b0101;
    repeat (3) tick();
    check("t5_no_ack", 32'(Grant_Ack), 0);
    RSTn = 1'b1;
    wait_en(n);
    check("t5_restart", 32'(Grant_Id), 0);
    frame();
    Req = 4'b0100;
    wait_en(n);
    check("t5_next", 32'(Grant_Id), 2);
    frame();
    Req = '0;
    tick();

    // Transmitter never answers.
    Req = 4'b1000;
    wait_en(n);
`ifdef TX_ARB_TIMEOUT_EN
    n = 0;
    while (Tx_Err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("t6_cycles", n, TO);
    check("t6_en", 32'(TX_En_Sig), 0);
    check("t6_ack", 32'(Grant_Ack), 0);
    Req = '0;
    tick();
    check("t6_err_clear", 32'(Tx_Err), 0);
`else
    repeat (40) tick();
    check("t6_busy", 32'(Busy), 1);
    check("t6_err", 32'(Tx_Err), 0);
    check("t6_en", 32'(TX_En_Sig), 1);
    frame();
    Req = '0;
    check("t6_late_ack", 32'(Grant_Ack), 32'b1000);
`endif
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
